// File: rtl/mem_stage.sv
// Memory pipeline stage: latches the EX result, extracts sign/zero-extended
// load data from the data SRAM read port, and stalls the pipeline until the
// read data strobe arrives. A one-word buffer keeps load data that arrived
// while the stage itself was held by the rest of the pipeline.
module mem_stage #(
   parameter int EX_TO_MEM_WD = 79,
   parameter int MEM_TO_WB_WD = 70,
   parameter int STALL_WD     = 6
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
   input  logic                    data_sram_rvalid,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [37:0]             mem_to_id_bus,
   output logic                    stallreq_for_mem
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HOLD
   } MemState;

   MemState                 r_state;
   MemState                 w_nextState;
   logic [EX_TO_MEM_WD-1:0] r_exMemBus;
   logic [31:0]             r_loadBuffer;

   logic [31:0] w_pc;
   logic [2:0]  w_memOp;
   logic        w_dataRamEn;
   logic [3:0]  w_dataRamWen;
   logic        w_selRfRes;
   logic        w_rfWe;
   logic [4:0]  w_rfWaddr;
   logic [31:0] w_exResult;

   logic        w_isLoad;
   logic        w_rvalidUsed;
   logic        w_waiting;
   logic        w_capture;
   logic [31:0] w_rawData;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_loadData;
   logic [31:0] w_rfWdata;
   logic        w_outWe;
   logic        w_memStop;
   logic        w_unusedStall;

   assign w_memStop     = stall[3];
   assign w_unusedStall = ^stall;

   assign w_pc         = r_exMemBus[78:47];
   assign w_memOp      = r_exMemBus[46:44];
   assign w_dataRamEn  = r_exMemBus[43];
   assign w_dataRamWen = r_exMemBus[42:39];
   assign w_selRfRes   = r_exMemBus[38];
   assign w_rfWe       = r_exMemBus[37];
   assign w_rfWaddr    = r_exMemBus[36:32];
   assign w_exResult   = r_exMemBus[31:0];

   // Only a real load waits for the SRAM; stores and ALU results pass straight through.
   assign w_isLoad     = w_dataRamEn && (w_dataRamWen == 4'b0000) && w_selRfRes;
   assign w_rvalidUsed = data_sram_rvalid && (((r_state == IDLE) && w_isLoad) || (r_state == WAIT));
   assign w_waiting    = !data_sram_rvalid && (((r_state == IDLE) && w_isLoad) || (r_state == WAIT));
   assign w_capture    = w_rvalidUsed && w_memStop;

   // Input register: bubble when MEM stops but WB drains, load when MEM advances, else hold.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_exMemBus <= '0;
      end else if (stall[3] && !stall[4]) begin
         r_exMemBus <= '0;
      end else if (!stall[3]) begin
         r_exMemBus <= ex_to_mem_bus;
      end
   end

   // Load-wait state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Keep read data that arrived while this stage was frozen by a downstream stall.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_loadBuffer <= '0;
      end else if (w_capture) begin
         r_loadBuffer <= data_sram_rdata;
      end
   end

   // Next-state logic for the load-wait FSM.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_isLoad) begin
               if (!data_sram_rvalid) begin
                  w_nextState = WAIT;
               end else if (w_memStop) begin
                  w_nextState = HOLD;
               end
            end
         end
         WAIT: begin
            if (data_sram_rvalid) begin
               w_nextState = w_memStop ? HOLD : IDLE;
            end
         end
         HOLD: begin
            if (!w_memStop) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Lane selection and sign/zero extension of the load word.
   always_comb begin
      w_rawData = (r_state == HOLD) ? r_loadBuffer : data_sram_rdata;
      w_byte    = w_rawData[7:0];
      case (w_exResult[1:0])
         2'd0:    w_byte = w_rawData[7:0];
         2'd1:    w_byte = w_rawData[15:8];
         2'd2:    w_byte = w_rawData[23:16];
         default: w_byte = w_rawData[31:24];
      endcase
      w_half = w_exResult[1] ? w_rawData[31:16] : w_rawData[15:0];
      case (w_memOp)
         3'b001:  w_loadData = {{24{w_byte[7]}}, w_byte};
         3'b010:  w_loadData = {24'd0, w_byte};
         3'b011:  w_loadData = {{16{w_half[15]}}, w_half};
         3'b100:  w_loadData = {16'd0, w_half};
         default: w_loadData = w_rawData;
      endcase
   end

   // Writeback/forwarding outputs; write enable is suppressed while load data is outstanding.
   always_comb begin
      w_rfWdata        = w_selRfRes ? w_loadData : w_exResult;
      w_outWe          = w_rfWe && !w_waiting;
      stallreq_for_mem = w_waiting;
      mem_to_wb_bus    = {w_pc, w_outWe, w_rfWaddr, w_rfWdata};
      mem_to_id_bus    = {w_outWe, w_rfWaddr, w_rfWdata};
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter EX_TO_MEM_WD, default 79, SHALL be the width of ex_to_mem_bus.
REQ-002 Parameter MEM_TO_WB_WD, default 70, SHALL be the width of mem_to_wb_bus.
REQ-003 Parameter STALL_WD, default 6, SHALL be the width of stall.
REQ-004 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 resetn  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 stall  in  STALL_WD  SHALL be the pipeline stall vector; bit 3 holds MEM, bit 4 holds WB.
REQ-007 ex_to_mem_bus  in  79  SHALL be {pc[31:0], mem_op[2:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}, MSB first.
REQ-008 data_sram_rdata  in  32  SHALL be the read data for the load request issued from EX.
REQ-009 data_sram_rvalid  in  1  SHALL be a one-cycle strobe qualifying data_sram_rdata; earliest arrival is the first cycle the load occupies MEM.
REQ-010 mem_to_wb_bus  out  70  SHALL be {pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
REQ-011 mem_to_id_bus  out  38  SHALL be {rf_we, rf_waddr[4:0], rf_wdata[31:0]} for forwarding.
REQ-012 stallreq_for_mem  out  1  SHALL request a pipeline stall while load data is outstanding.

Function
REQ-013 Input register: stall[3]=Stop and stall[4]=NoStop loads all-zero (bubble); stall[3]=NoStop loads ex_to_mem_bus; otherwise holds.
REQ-014 "Load" SHALL mean registered data_ram_en=1, data_ram_wen=4'b0000 and sel_rf_res=1; stores and ALU ops never wait.
REQ-015 mem_op encoding SHALL be 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; other codes behave as LW.
REQ-016 Byte lane SHALL be ex_result[1:0] (lane 0 = rdata[7:0]); halfword lane SHALL be ex_result[1] (0 = rdata[15:0]); LW ignores ex_result[1:0]; no misalignment exception.
REQ-017 LB/LH SHALL sign-extend and LBU/LHU zero-extend to 32 bits.
REQ-018 rf_wdata SHALL be the extracted load data when sel_rf_res=1, else ex_result.
REQ-019 FSM states: IDLE, WAIT, HOLD; reset state IDLE.
REQ-020 IDLE: a newly latched load with rvalid=0 -> WAIT; a load with rvalid=1 in that cycle uses rdata combinationally, with no stall.
REQ-021 IDLE, same-cycle rvalid case: if stall[3]=Stop in that cycle, rdata SHALL be captured into a 32-bit buffer -> HOLD.
REQ-022 WAIT: stallreq_for_mem=1; mem_to_wb_bus and mem_to_id_bus rf_we forced 0.
REQ-023 WAIT, on rvalid=1: stallreq deasserts the same cycle and rdata is used combinationally; go IDLE if stall[3]=NoStop, else capture into buffer and go HOLD.
REQ-024 HOLD: buffer supplies load data; state returns to IDLE on the first cycle with stall[3]=NoStop.
REQ-025 rvalid in IDLE with no load latched, or in HOLD, SHALL be ignored.
REQ-026 Load-to-use latency: data appears on mem_to_id_bus in the cycle rvalid is seen; no extra register stage.
REQ-027 Outputs other than the buffer path SHALL be combinational from the input register.

Reset
REQ-028 While resetn=0 at a rising edge, the input register SHALL clear to zero, the FSM SHALL go IDLE and the buffer SHALL clear.
REQ-029 After reset, all outputs SHALL be 0, including stallreq_for_mem.
REQ-030 Reset asserted in WAIT SHALL abandon the load; a subsequent stale rvalid SHALL be ignored.

Verification
REQ-031 ALU op: ex_result=0x1234_5678, rf_we=1, waddr=5, sel_rf_res=0 -> next cycle mem_to_wb_bus rf_wdata=0x1234_5678, we=1, waddr=5, stallreq=0.
REQ-032 LB at addr ...03 with rdata=0x80FF_0000 and rvalid in the first MEM cycle -> rf_wdata=0xFFFF_FF80, no stall; the same case as LBU -> 0x0000_0080.
REQ-033 LHU at addr ...02 with rvalid 3 cycles late and rdata=0xBEEF_0001 -> stallreq=1 for 3 cycles, we=0 meanwhile, then rf_wdata=0x0000_BEEF.
REQ-034 LW: rvalid arrives while stall[3]=Stop, with rdata=0xCAFE_F00D followed by rdata changing -> buffer holds; released rf_wdata=0xCAFE_F00D.
REQ-035 resetn=0 during WAIT, then rvalid pulse -> state IDLE, outputs 0, no write.
REQ-036 stall[3]=Stop with stall[4]=NoStop -> next cycle bubble: mem_to_wb_bus=0.
